// File: rtl/tc_fetch_pkg.sv
// Shared widths and queue entry type for the instruction fetch queue.
package tc_fetch_pkg;
   localparam int ADDR_W       = 16;
   localparam int INSTR_W      = 32;
   localparam int FETCH_STRIDE = 4;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] data;
   } fetch_entry_t;
endpackage

// File: rtl/tc_fetch_fifo.sv
// Power-of-two entry queue with push, pop and flush; the head is read combinationally.
module tc_fetch_fifo
   import tc_fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  fetch_entry_t  push_entry,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_ok;

   assign pop_ok = pop && (count_q != '0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Full queue with a pop overwrites the slot being read out on the same edge.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/tc_fetch_queue8_4.sv
// Credit-limited instruction fetch front end feeding a decoder queue.
// Optional TC_FETCH_PERF_EN adds saturating push/redirect counters.
module tc_fetch_queue8_4
   import tc_fetch_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  prog_addr,
   input  logic [7:0]         prog_out0,
   input  logic [7:0]         prog_out1,
   input  logic [7:0]         prog_out2,
   input  logic [7:0]         prog_out3,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_data,
`ifdef TC_FETCH_PERF_EN
   output logic [15:0]        fetch_count,
   output logic [15:0]        flush_count,
`endif
   output logic [ADDR_W-1:0]  instr_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic [CW-1:0]     count;
   logic [CW-1:0]     occupancy;
   fetch_entry_t      head;
   fetch_entry_t      push_entry;
   logic              issue, push, pop;

   // Credits count the returning fetch so a full queue can never overflow.
   assign occupancy  = count + CW'(inflight_q);
   assign issue      = !redirect_valid && (occupancy < CW'(DEPTH));
   assign push       = inflight_q && !redirect_valid;
   assign pop        = instr_valid && instr_ready && !redirect_valid;
   assign push_entry = '{pc: inflight_pc_q, data: {prog_out3, prog_out2, prog_out1, prog_out0}};

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_addr;
      end else if (issue) begin
         fetch_pc_d    = fetch_pc_q + ADDR_W'(FETCH_STRIDE);
         inflight_d    = 1'b1;
         inflight_pc_d = fetch_pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   tc_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .count      (count),
      .head       (head)
   );

   assign prog_addr   = fetch_pc_q;
   assign instr_valid = (count != '0);
   assign instr_data  = instr_valid ? head.data : '0;
   assign instr_pc    = instr_valid ? head.pc   : '0;

`ifdef TC_FETCH_PERF_EN
   logic [15:0] fetch_count_q, fetch_count_d;
   logic [15:0] flush_count_q, flush_count_d;

   always_comb begin
      fetch_count_d = fetch_count_q;
      flush_count_d = flush_count_q;
      if (push && (fetch_count_q != 16'hFFFF))           fetch_count_d = fetch_count_q + 16'd1;
      if (redirect_valid && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_tc_fetch_queue8_4.sv
// Directed bench for the fetch queue: streaming, stall, redirect, wrap and async reset.
module tb_tc_fetch_queue8_4;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] prog_addr, prog_addr2;
   logic [7:0]  p0, p1, p2, p3;
   logic [7:0]  q0, q1, q2, q3;
   logic        redirect_valid;
   logic [15:0] redirect_addr;
   logic        instr_valid, instr_valid2;
   logic        instr_ready;
   logic [31:0] instr_data, instr_data2;
   logic [15:0] instr_pc, instr_pc2;
`ifdef TC_FETCH_PERF_EN
   logic [15:0] fetch_count, flush_count, fetch_count2, flush_count2;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Program memory model: byte value equals its address low byte, one cycle latency.
   always @(posedge clk) begin
      p0 <= prog_addr[7:0];
      p1 <= prog_addr[7:0] + 8'd1;
      p2 <= prog_addr[7:0] + 8'd2;
      p3 <= prog_addr[7:0] + 8'd3;
      q0 <= prog_addr2[7:0];
      q1 <= prog_addr2[7:0] + 8'd1;
      q2 <= prog_addr2[7:0] + 8'd2;
      q3 <= prog_addr2[7:0] + 8'd3;
   end

   tc_fetch_queue8_4 u_dut (
      .clk            (clk),
      .rst            (rst),
      .prog_addr      (prog_addr),
      .prog_out0      (p0),
      .prog_out1      (p1),
      .prog_out2      (p2),
      .prog_out3      (p3),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
`ifdef TC_FETCH_PERF_EN
      .fetch_count    (fetch_count),
      .flush_count    (flush_count),
`endif
      .instr_pc       (instr_pc)
   );

   tc_fetch_queue8_4 #(.RESET_PC(16'hFFF8)) u_dut_wrap (
      .clk            (clk),
      .rst            (rst),
      .prog_addr      (prog_addr2),
      .prog_out0      (q0),
      .prog_out1      (q1),
      .prog_out2      (q2),
      .prog_out3      (q3),
      .redirect_valid (1'b0),
      .redirect_addr  (16'h0000),
      .instr_valid    (instr_valid2),
      .instr_ready    (1'b1),
      .instr_data     (instr_data2),
`ifdef TC_FETCH_PERF_EN
      .fetch_count    (fetch_count2),
      .flush_count    (flush_count2),
`endif
      .instr_pc       (instr_pc2)
   );

   function automatic logic [31:0] exp_data(input logic [15:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1 time unit after an edge with reset just released; the next edge is edge 1.
   task automatic do_reset();
      rst = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      instr_ready = 1'b1;
      rst = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr = 16'h0000;
      #2;
      tests++; if (prog_addr !== 16'h0000) begin fails++; $display("FAIL reset_prog_addr: got %h expected 0000", prog_addr); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
      tests++; if (instr_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 00000000", instr_data); end
      tests++; if (instr_pc !== 16'h0) begin fails++; $display("FAIL reset_pc: got %h expected 0000", instr_pc); end
   endtask

   task automatic test_stream();
      logic [15:0] exp_pc;
      instr_ready = 1'b1;
      do_reset();
      tick();
      tests++; if (prog_addr !== 16'h0004) begin fails++; $display("FAIL stream_addr_e1: got %h expected 0004", prog_addr); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stream_valid_e1: got %b expected 0", instr_valid); end
      tick();
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stream_valid_e2: got %b expected 1", instr_valid); end
      tests++; if (instr_pc !== 16'h0000) begin fails++; $display("FAIL stream_pc_e2: got %h expected 0000", instr_pc); end
      tests++; if (instr_data !== 32'h03020100) begin fails++; $display("FAIL stream_data_e2: got %h expected 03020100", instr_data); end
      tests++; if (prog_addr !== 16'h0008) begin fails++; $display("FAIL stream_addr_e2: got %h expected 0008", prog_addr); end
      for (int k = 3; k <= 8; k++) begin
         tick();
         exp_pc = 16'((k - 2) * 4);
         tests++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin fails++; $display("FAIL stream_pc_e%0d: got v=%b %h expected v=1 %h", k, instr_valid, instr_pc, exp_pc); end
         tests++; if (instr_data !== exp_data(exp_pc)) begin fails++; $display("FAIL stream_data_e%0d: got %h expected %h", k, instr_data, exp_data(exp_pc)); end
      end
   endtask

   task automatic test_stall();
      instr_ready = 1'b0;
      do_reset();
      repeat (2) tick();
      for (int k = 3; k <= 9; k++) begin
         tick();
         tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== 32'h03020100) begin fails++; $display("FAIL stall_head_e%0d: got v=%b pc=%h d=%h expected v=1 pc=0000 d=03020100", k, instr_valid, instr_pc, instr_data); end
      end
      tests++; if (prog_addr !== 16'h0010) begin fails++; $display("FAIL stall_prog_addr: got %h expected 0010", prog_addr); end
   endtask

   task automatic test_redirect();
      instr_ready = 1'b0;
      do_reset();
      repeat (4) tick();
      redirect_valid = 1'b1;
      redirect_addr = 16'h0040;
      tick();
      redirect_valid = 1'b0;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_flush_valid: got %b expected 0", instr_valid); end
      tests++; if (prog_addr !== 16'h0040) begin fails++; $display("FAIL redir_prog_addr: got %h expected 0040", prog_addr); end
      tick();
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_stale_dropped: got v=%b pc=%h expected v=0", instr_valid, instr_pc); end
      tests++; if (prog_addr !== 16'h0044) begin fails++; $display("FAIL redir_issue_target: got %h expected 0044", prog_addr); end
      tick();
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040) begin fails++; $display("FAIL redir_first_pc: got v=%b %h expected v=1 0040", instr_valid, instr_pc); end
      tests++; if (instr_data !== 32'h43424140) begin fails++; $display("FAIL redir_first_data: got %h expected 43424140", instr_data); end
      instr_ready = 1'b1;
      tick();
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0044) begin fails++; $display("FAIL redir_second_pc: got v=%b %h expected v=1 0044", instr_valid, instr_pc); end
      tick();
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0048) begin fails++; $display("FAIL redir_third_pc: got v=%b %h expected v=1 0048", instr_valid, instr_pc); end
   endtask

   task automatic test_redirect_pop();
      instr_ready = 1'b1;
      do_reset();
      repeat (6) tick();
      redirect_valid = 1'b1;
      redirect_addr = 16'h0082;
      tick();
      redirect_valid = 1'b0;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rpop_flush_valid: got v=%b pc=%h expected v=0", instr_valid, instr_pc); end
      tick();
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rpop_no_old: got v=%b pc=%h expected v=0", instr_valid, instr_pc); end
      for (int k = 0; k < 3; k++) begin
         tick();
         tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'(16'h0082 + 4 * k)) begin fails++; $display("FAIL rpop_pc_%0d: got v=%b %h expected v=1 %h", k, instr_valid, instr_pc, 16'(16'h0082 + 4 * k)); end
         tests++; if (instr_data !== exp_data(16'(16'h0082 + 4 * k))) begin fails++; $display("FAIL rpop_data_%0d: got %h expected %h", k, instr_data, exp_data(16'(16'h0082 + 4 * k))); end
      end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_pc [4];
      exp_pc[0] = 16'hFFF8; exp_pc[1] = 16'hFFFC; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0004;
      do_reset();
      tests++; if (prog_addr2 !== 16'hFFF8) begin fails++; $display("FAIL wrap_reset_addr: got %h expected FFF8", prog_addr2); end
      tick();
      for (int k = 0; k < 4; k++) begin
         tick();
         tests++; if (instr_valid2 !== 1'b1 || instr_pc2 !== exp_pc[k]) begin fails++; $display("FAIL wrap_pc_%0d: got v=%b %h expected v=1 %h", k, instr_valid2, instr_pc2, exp_pc[k]); end
         tests++; if (instr_data2 !== exp_data(exp_pc[k])) begin fails++; $display("FAIL wrap_data_%0d: got %h expected %h", k, instr_data2, exp_data(exp_pc[k])); end
      end
   endtask

   task automatic test_async_reset();
      instr_ready = 1'b0;
      do_reset();
      repeat (6) tick();
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL areset_pre_full: got %b expected 1", instr_valid); end
      #3;
      rst = 1'b0;
      #1;
      tests++; if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 16'h0) begin fails++; $display("FAIL areset_outputs: got v=%b d=%h pc=%h expected all zero", instr_valid, instr_data, instr_pc); end
      tests++; if (prog_addr !== 16'h0000) begin fails++; $display("FAIL areset_prog_addr: got %h expected 0000", prog_addr); end
`ifdef TC_FETCH_PERF_EN
      tests++; if (fetch_count !== 16'h0 || flush_count !== 16'h0) begin fails++; $display("FAIL areset_counters: got %h %h expected 0000 0000", fetch_count, flush_count); end
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      instr_ready = 1'b1;
      tick();
      tests++; if (prog_addr !== 16'h0004 || instr_valid !== 1'b0) begin fails++; $display("FAIL areset_restart_e1: got addr=%h v=%b expected addr=0004 v=0", prog_addr, instr_valid); end
      tick();
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== 32'h03020100) begin fails++; $display("FAIL areset_restart_e2: got v=%b pc=%h d=%h expected v=1 pc=0000 d=03020100", instr_valid, instr_pc, instr_data); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_pop();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
